// File: rtl/mbox_req_arb_pkg.sv
// Shared types and defaults for the MBOX request arbiter.
// Owner encoding, FSM state codes and the ack decode helper live here so the
// arbiter top and its priority picker agree on them.
package mbox_req_arb_pkg;

   // Default WAIT-cycle budget before a silent cycle is declared NXM.
   localparam int TIMEOUT_DFLT    = 64;
   // Default number of consecutive EBOX grants tolerated while SWP waits.
   localparam int STARVE_MAX_DFLT = 4;

   // Physical address, PDP-10 bit numbering (bit 13 is the MSB).
   typedef logic [13:35] mboxAdrT;

   // Current owner of the MBOX port.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_CHAN = 2'd1,
      SRC_EBOX = 2'd2,
      SRC_SWP  = 2'd3
   } mboxSrcT;

   // Cycle sequencer states (plain constants for legacy compatibility).
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Owner to one-hot ack vector, ordered {swp, ebox, chan}.
   function automatic logic [2:0] srcAckDecode(input mboxSrcT src);
      logic [2:0] vec;
      case (src)
         SRC_CHAN: vec = 3'b001;
         SRC_EBOX: vec = 3'b010;
         SRC_SWP:  vec = 3'b100;
         default:  vec = 3'b000;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/mbox_req_arb_pick.sv
// Priority picker for the MBOX request arbiter.
// CHAN beats EBOX beats SWP, except that once EBOX has been granted
// STARVE_MAX times in a row while SWP was waiting, SWP jumps ahead of EBOX.
// The starve counter only moves while the sequencer is idle (strobe high),
// which is the only time the winner is actually taken.
module mbox_req_arb_pick
   import mbox_req_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
   input  logic    clk,
   input  logic    CROBAR,
   input  logic    chanReq,
   input  logic    eboxReq,
   input  logic    swpReq,
   input  logic    strobe,
   output mboxSrcT winSrc,
   output logic    grant
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] starveCnt;
   logic [CNT_W-1:0] starveNext;
   logic             atMax;

   assign atMax = (starveCnt == CNT_MAX);

   // Winner selection: fixed priority with the SWP anti-starvation override.
   always_comb begin
      winSrc = SRC_NONE;
      grant  = 1'b0;
      if (chanReq) begin
         winSrc = SRC_CHAN;
         grant  = 1'b1;
      end else if (swpReq && atMax) begin
         winSrc = SRC_SWP;
         grant  = 1'b1;
      end else if (eboxReq) begin
         winSrc = SRC_EBOX;
         grant  = 1'b1;
      end else if (swpReq) begin
         winSrc = SRC_SWP;
         grant  = 1'b1;
      end else begin
         winSrc = SRC_NONE;
         grant  = 1'b0;
      end
   end

   // Starve count update: count EBOX wins over a waiting SWP, clear when SWP wins or stops asking.
   always_comb begin
      starveNext = starveCnt;
      if (strobe) begin
         if (grant && (winSrc == SRC_SWP)) begin
            starveNext = CNT_ZERO;
         end else if (!swpReq) begin
            starveNext = CNT_ZERO;
         end else if (grant && (winSrc == SRC_EBOX) && !atMax) begin
            starveNext = starveCnt + CNT_ONE;
         end else begin
            starveNext = starveCnt;
         end
      end else begin
         starveNext = starveCnt;
      end
   end

   // Starve counter register.
   always_ff @(posedge clk) begin
      if (CROBAR) begin
         starveCnt <= CNT_ZERO;
      end else begin
         starveCnt <= starveNext;
      end
   end

endmodule

// File: rtl/mbox_req_arb.sv
// MBOX request arbiter.
// Picks one of CHAN / EBOX / SWP, latches its address and write flag, strobes
// MBOX_REQ, then waits for completion, a retry demand or a timeout, and finally
// pulses the owner's ack. A silent cycle is ended after TIMEOUT WAIT cycles and
// reported as NXM. Every output comes straight from a flop.
module mbox_req_arb
   import mbox_req_arb_pkg::*;
#(
   parameter int TIMEOUT    = TIMEOUT_DFLT,
   parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
   input  logic       clk,
   input  logic       CROBAR,
   input  logic       chanReq,
   input  mboxAdrT    chanAdr,
   input  logic       chanWrite,
   input  logic       eboxReq,
   input  mboxAdrT    eboxAdr,
   input  logic       eboxWrite,
   input  logic       swpReq,
   input  mboxAdrT    swpAdr,
   input  logic       swpWrite,
   input  logic       mboxRespIn,
   input  logic       mboxRetry,
   output logic       MBOX_REQ,
   output mboxAdrT    MBOX_ADR,
   output logic       MBOX_WR,
   output logic [1:0] MBOX_SRC,
   output logic       chanAck,
   output logic       eboxAck,
   output logic       swpAck,
   output logic       ackErr,
   output logic       memTimeout,
   output logic       busy
);

   // One extra bit so the terminal count is representable without wrap.
   localparam int TMR_W = $clog2(TIMEOUT) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam mboxAdrT          ADR_ZERO = 23'd0;

   logic [1:0]       state;
   logic [1:0]       nextState;
   logic [TMR_W-1:0] timer;
   mboxSrcT          curSrc;
   mboxSrcT          winSrc;
   logic             grant;
   logic             idleStrobe;
   mboxAdrT          winAdr;
   logic             winWr;
   logic [2:0]       ackVec;
   logic             respHit;
   logic             retryHit;
   logic             timeoutHit;
   logic             enterDone;

   assign idleStrobe = (state == ST_IDLE);
   assign MBOX_SRC   = curSrc;

   mbox_req_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) uPick (
      .clk     (clk),
      .CROBAR  (CROBAR),
      .chanReq (chanReq),
      .eboxReq (eboxReq),
      .swpReq  (swpReq),
      .strobe  (idleStrobe),
      .winSrc  (winSrc),
      .grant   (grant)
   );

   // Route the winning requester's address and write flag toward the latches.
   always_comb begin
      winAdr = ADR_ZERO;
      winWr  = 1'b0;
      case (winSrc)
         SRC_CHAN: begin
            winAdr = chanAdr;
            winWr  = chanWrite;
         end
         SRC_EBOX: begin
            winAdr = eboxAdr;
            winWr  = eboxWrite;
         end
         SRC_SWP: begin
            winAdr = swpAdr;
            winWr  = swpWrite;
         end
         default: begin
            winAdr = ADR_ZERO;
            winWr  = 1'b0;
         end
      endcase
   end

   // WAIT-state events in precedence order: response, then retry, then timeout.
   always_comb begin
      respHit    = 1'b0;
      retryHit   = 1'b0;
      timeoutHit = 1'b0;
      if (state == ST_WAIT) begin
         respHit    = mboxRespIn;
         retryHit   = !mboxRespIn && mboxRetry;
         timeoutHit = !mboxRespIn && !mboxRetry && (timer == TMR_LAST);
      end else begin
         respHit    = 1'b0;
         retryHit   = 1'b0;
         timeoutHit = 1'b0;
      end
   end

   // Cycle sequencer next-state decode.
   always_comb begin
      nextState = state;
      case (state)
         ST_IDLE: begin
            if (grant) begin
               nextState = ST_ISSUE;
            end else begin
               nextState = ST_IDLE;
            end
         end
         ST_ISSUE: nextState = ST_WAIT;
         ST_WAIT: begin
            if (respHit || timeoutHit) begin
               nextState = ST_DONE;
            end else if (retryHit) begin
               nextState = ST_ISSUE;
            end else begin
               nextState = ST_WAIT;
            end
         end
         ST_DONE: nextState = ST_IDLE;
         default: nextState = ST_IDLE;
      endcase
   end

   assign enterDone = (state == ST_WAIT) && (nextState == ST_DONE);
   assign ackVec    = srcAckDecode(curSrc);

   // State register plus the MBOX_REQ strobe and busy flag that follow it.
   always_ff @(posedge clk) begin
      if (CROBAR) begin
         state    <= ST_IDLE;
         MBOX_REQ <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= nextState;
         MBOX_REQ <= (nextState == ST_ISSUE);
         busy     <= (nextState != ST_IDLE);
      end
   end

   // WAIT timer: zeroed on every issue, counts up while waiting.
   always_ff @(posedge clk) begin
      if (CROBAR) begin
         timer <= TMR_ZERO;
      end else begin
         case (state)
            ST_ISSUE: timer <= TMR_ZERO;
            ST_WAIT:  timer <= timer + TMR_ONE;
            default:  timer <= timer;
         endcase
      end
   end

   // Cycle latches: capture the winner in IDLE, hold through DONE, clear on the way back to IDLE.
   always_ff @(posedge clk) begin
      if (CROBAR) begin
         curSrc   <= SRC_NONE;
         MBOX_ADR <= ADR_ZERO;
         MBOX_WR  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  curSrc   <= winSrc;
                  MBOX_ADR <= winAdr;
                  MBOX_WR  <= winWr;
               end else begin
                  curSrc   <= SRC_NONE;
                  MBOX_ADR <= ADR_ZERO;
                  MBOX_WR  <= 1'b0;
               end
            end
            ST_DONE: begin
               curSrc   <= SRC_NONE;
               MBOX_ADR <= ADR_ZERO;
               MBOX_WR  <= 1'b0;
            end
            default: begin
               curSrc   <= curSrc;
               MBOX_ADR <= MBOX_ADR;
               MBOX_WR  <= MBOX_WR;
            end
         endcase
      end
   end

   // Completion pulses: owner ack with error qualifier, and the NXM pulse on timeout.
   always_ff @(posedge clk) begin
      if (CROBAR) begin
         chanAck    <= 1'b0;
         eboxAck    <= 1'b0;
         swpAck     <= 1'b0;
         ackErr     <= 1'b0;
         memTimeout <= 1'b0;
      end else begin
         chanAck    <= enterDone & ackVec[0];
         eboxAck    <= enterDone & ackVec[1];
         swpAck     <= enterDone & ackVec[2];
         ackErr     <= timeoutHit;
         memTimeout <= timeoutHit;
      end
   end

endmodule
